load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 279 +++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I load/store requests into data-memory bus
// commands. Aligned accesses use one bus cycle with a lane mask; misaligned
// accesses are either split into byte accesses or rejected with an error,
// depending on ALLOW_MISALIGNED.

package MemoryBus;
    typedef struct packed {
        logic [29:0] address;     // word index
        logic [31:0] write_data;  // LSB-justified store data
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  mask_byte;
    } Cmd;

    typedef struct packed {
        logic [31:0] read_data;
    } Result;
endpackage

module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic             resp_error,
    output MemoryBus::Cmd    membuscmd,
    input  MemoryBus::Result membusres
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam MemoryBus::Cmd CMD_IDLE = '{
        address:    30'd0,
        write_data: 32'd0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mask_byte:  4'd0
    };

    // Loads accept all five width codes, stores only SB/SH/SW.
    function automatic logic is_legal(input logic write, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'd0, 3'd1, 3'd2: ok = 1'b1;
            3'd4, 3'd5:       ok = ~write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Bytes are never misaligned; halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (size)
            2'd1:    mis = lo[0];
            2'd2:    mis = (lo != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Store data stays in the low bits; the mask tells memory which lanes.
    function automatic logic [31:0] lsb_justify(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] v;
        v = wd;
        case (size)
            2'd0:    v = {24'd0, wd[7:0]};
            2'd1:    v = {16'd0, wd[15:0]};
            default: v = wd;
        endcase
        return v;
    endfunction

    function automatic MemoryBus::Cmd aligned_cmd(input logic write, input logic [1:0] size,
                                                  input logic [31:0] a, input logic [31:0] wd);
        MemoryBus::Cmd c;
        c            = CMD_IDLE;
        c.address    = a[31:2];
        c.write_data = write ? lsb_justify(size, wd) : 32'd0;
        c.mem_read   = ~write;
        c.mem_write  = write;
        case (size)
            2'd0:    c.mask_byte = 4'b0001 << a[1:0];
            2'd1:    c.mask_byte = 4'b0011 << a[1:0];
            default: c.mask_byte = 4'b1111;
        endcase
        return c;
    endfunction

    function automatic MemoryBus::Cmd byte_cmd(input logic write, input logic [31:0] a,
                                               input logic [7:0] b);
        MemoryBus::Cmd c;
        c            = CMD_IDLE;
        c.address    = a[31:2];
        c.write_data = write ? {24'd0, b} : 32'd0;
        c.mem_read   = ~write;
        c.mem_write  = write;
        c.mask_byte  = 4'b0001 << a[1:0];
        return c;
    endfunction

    function automatic logic [7:0] select_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        b = w[7:0];
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] v;
        v = 32'd0;
        case (f3)
            3'd0:    v = {{24{raw[7]}}, raw[7:0]};
            3'd1:    v = {{16{raw[15]}}, raw[15:0]};
            3'd2:    v = raw;
            3'd4:    v = {24'd0, raw[7:0]};
            3'd5:    v = {16'd0, raw[15:0]};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    state_t        state_r;
    logic          req_ready_r;
    logic          resp_valid_r;
    logic          resp_error_r;
    logic [31:0]   resp_data_r;
    MemoryBus::Cmd cmd_r;
    logic          write_r;
    logic [2:0]    funct3_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic          split_r;
    logic [1:0]    cnt_r;
    logic [1:0]    last_cnt_r;
    logic [31:0]   raw_r;

    logic          legal_s;
    logic          misaligned_s;
    logic          reject_s;
    logic          split_s;
    logic [1:0]    cnt_next_s;
    logic [31:0]   byte_addr_s;
    logic [31:0]   next_byte_addr_s;
    logic [7:0]    lane_byte_s;
    logic [31:0]   raw_next_s;

    // Classify the incoming request: legal width code, alignment, split or reject.
    always_comb begin
        legal_s      = is_legal(req_write, req_funct3);
        misaligned_s = is_misaligned(req_funct3[1:0], req_addr[1:0]);
        reject_s     = ~legal_s | (misaligned_s & ~ALLOW_MISALIGNED);
        split_s      = misaligned_s & ALLOW_MISALIGNED;
    end

    // Byte-split addressing and load-data assembly for the current ACCESS cycle.
    always_comb begin
        cnt_next_s       = cnt_r + 2'd1;
        byte_addr_s      = addr_r + {30'd0, cnt_r};
        next_byte_addr_s = addr_r + {30'd0, cnt_next_s};
        lane_byte_s      = select_byte(membusres.read_data, byte_addr_s[1:0]);
        raw_next_s       = raw_r;
        if (split_r) begin
            case (cnt_r)
                2'd0:    raw_next_s[7:0]   = lane_byte_s;
                2'd1:    raw_next_s[15:8]  = lane_byte_s;
                2'd2:    raw_next_s[23:16] = lane_byte_s;
                default: raw_next_s[31:24] = lane_byte_s;
            endcase
        end else begin
            raw_next_s = membusres.read_data >> {addr_r[1:0], 3'b000};
        end
    end

    // Request FSM with registered bus command and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_data_r  <= 32'd0;
            cmd_r        <= CMD_IDLE;
            write_r      <= 1'b0;
            funct3_r     <= 3'd0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            split_r      <= 1'b0;
            cnt_r        <= 2'd0;
            last_cnt_r   <= 2'd0;
            raw_r        <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        write_r     <= req_write;
                        funct3_r    <= req_funct3;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        split_r     <= split_s;
                        cnt_r       <= 2'd0;
                        last_cnt_r  <= split_s ? ((req_funct3[1:0] == 2'd2) ? 2'd3 : 2'd1) : 2'd0;
                        raw_r       <= 32'd0;
                        req_ready_r <= 1'b0;
                        if (reject_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_error_r <= 1'b1;
                            resp_data_r  <= 32'd0;
                            cmd_r        <= CMD_IDLE;
                        end else begin
                            state_r <= ACCESS;
                            cmd_r   <= split_s ? byte_cmd(req_write, req_addr, req_wdata[7:0])
                                               : aligned_cmd(req_write, req_funct3[1:0],
                                                             req_addr, req_wdata);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    raw_r <= raw_next_s;
                    if (cnt_r == last_cnt_r) begin
                        state_r      <= RESP;
                        cmd_r        <= CMD_IDLE;
                        resp_valid_r <= 1'b1;
                        resp_error_r <= 1'b0;
                        resp_data_r  <= write_r ? 32'd0 : extend(funct3_r, raw_next_s);
                    end else begin
                        cnt_r <= cnt_next_s;
                        cmd_r <= byte_cmd(write_r, next_byte_addr_s,
                                          select_byte(wdata_r, cnt_next_s));
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                    resp_data_r  <= 32'd0;
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                    resp_data_r  <= 32'd0;
                    cmd_r        <= CMD_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_error = resp_error_r;
    assign resp_data  = resp_data_r;
    assign membuscmd  = cmd_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus random traffic,
// checked against a byte-addressed reference memory model.

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;   // 0: split-capable unit, 1: unit rejecting misaligned
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    logic rv0, rv1;
    logic rdy0, rdy1, vld0, vld1, err0, err1;
    logic [31:0] data0, data1;
    MemoryBus::Cmd    cmd0, cmd1;
    MemoryBus::Result res0, res1;

    logic rdy_m, vld_m, err_m;
    logic [31:0] data_m;
    MemoryBus::Cmd cmd_m;

    always #5 clk = ~clk;

    assign rv0 = req_valid & ~sel;
    assign rv1 = req_valid & sel;
    assign rdy_m  = sel ? rdy1  : rdy0;
    assign vld_m  = sel ? vld1  : vld0;
    assign err_m  = sel ? err1  : err0;
    assign data_m = sel ? data1 : data0;
    assign cmd_m  = sel ? cmd1  : cmd0;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(vld0), .resp_data(data0), .resp_error(err0),
        .membuscmd(cmd0), .membusres(res0)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(vld1), .resp_data(data1), .resp_error(err1),
        .membuscmd(cmd1), .membusres(res1)
    );

    // Bus-side memory: 256 words, lanes selected by mask, data LSB-justified.
    logic [31:0] mem0 [0:255];
    assign res0.read_data = mem0[cmd0.address[7:0]];
    assign res1.read_data = 32'h0;

    always @(posedge clk) begin
        if (cmd0.mem_write) begin
            int lo;
            lo = 0;
            for (int b = 3; b >= 0; b--) if (cmd0.mask_byte[b]) lo = b;
            for (int b = 0; b < 4; b++)
                if (cmd0.mask_byte[b])
                    mem0[cmd0.address[7:0]][8*b +: 8] <= cmd0.write_data[8*(b-lo) +: 8];
        end
    end

    // Reference model: flat byte memory aliased on byte address bits [9:0].
    logic [7:0] refb [0:1023];

    int tests = 0;
    int fails = 0;

    logic [29:0] q_addr [$];
    logic [3:0]  q_mask [$];
    logic [31:0] q_wd   [$];
    int          n_acc;
    logic [31:0] o_data;
    logic        o_err;
    int          o_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke_word(input int idx, input logic [31:0] w);
        mem0[idx] = w;
        for (int b = 0; b < 4; b++) refb[idx*4 + b] = w[8*b +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v, ba;
        int n;
        v = 32'd0;
        n = 1 << f3[1:0];
        for (int k = 0; k < n; k++) begin
            ba = a + k;
            v = v | ({24'd0, refb[ba[9:0]]} << (8*k));
        end
        case (f3)
            3'd0:    v = (v[7]  ? 32'hFFFFFF00 : 32'd0) | (v & 32'hFF);
            3'd1:    v = (v[15] ? 32'hFFFF0000 : 32'd0) | (v & 32'hFFFF);
            3'd4:    v = v & 32'hFF;
            3'd5:    v = v & 32'hFFFF;
            default: v = v;
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
        logic [31:0] ba;
        for (int k = 0; k < n; k++) begin
            ba = a + k;
            refb[ba[9:0]] = wd[8*k +: 8];
        end
    endtask

    // Issue one request, record every bus cycle up to the response.
    task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
        logic done;
        q_addr.delete(); q_mask.delete(); q_wd.delete();
        n_acc = 0; o_data = 32'd0; o_err = 1'b0; o_lat = 0;
        @(negedge clk);
        chk("ready_idle", {31'd0, rdy_m}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        done = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (!done) begin
                if (vld_m) begin
                    done = 1'b1; o_lat = cyc; o_data = data_m; o_err = err_m;
                    chk("bus_idle_at_resp",
                        {26'd0, cmd_m.mem_read, cmd_m.mem_write, cmd_m.mask_byte}, 32'd0);
                end else begin
                    n_acc++;
                    chk("rd_wr_dir", {30'd0, cmd_m.mem_read, cmd_m.mem_write},
                        w ? 32'd1 : 32'd2);
                    chk("busy_not_ready", {31'd0, rdy_m}, 32'd0);
                    q_addr.push_back(cmd_m.address);
                    q_mask.push_back(cmd_m.mask_byte);
                    q_wd.push_back(cmd_m.write_data);
                    @(negedge clk);
                end
            end
        end
        chk("resp_seen", {31'd0, done}, 32'd1);
    endtask

    // One request checked end to end against the reference model.
    task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
        logic legal, mis, exp_err;
        logic [31:0] exp_data, ba, lowmask;
        logic [29:0] ex_addr;
        logic [3:0] ex_mask;
        int n, exp_acc;
        n       = 1 << f3[1:0];
        legal   = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis     = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0);
        exp_err = !legal || (mis && sel);
        exp_acc = exp_err ? 0 : (mis ? n : 1);
        exp_data = (!exp_err && !w) ? ref_load(f3, a) : 32'd0;
        lowmask = (n >= 4) ? 32'hFFFFFFFF : ((32'd1 << (8*n)) - 32'd1);
        run(w, f3, a, wd);
        chk("resp_error", {31'd0, o_err}, {31'd0, exp_err});
        chk("resp_data", o_data, exp_data);
        chk("access_count", n_acc, exp_acc);
        chk("latency", o_lat, exp_acc + 1);
        for (int k = 0; k < exp_acc && k < n_acc; k++) begin
            if (mis) begin
                ba = a + k;
                ex_addr = ba[31:2];
                ex_mask = 4'b0001 << ba[1:0];
            end else begin
                ex_addr = a[31:2];
                ex_mask = (n == 1) ? (4'b0001 << a[1:0]) :
                          (n == 2) ? (4'b0011 << a[1:0]) : 4'b1111;
            end
            chk("acc_addr", {2'd0, q_addr[k]}, {2'd0, ex_addr});
            chk("acc_mask", {28'd0, q_mask[k]}, {28'd0, ex_mask});
            if (w) begin
                if (mis) chk("acc_wbyte", {24'd0, q_wd[k][7:0]}, {24'd0, wd[8*k +: 8]});
                else     chk("acc_wdata", q_wd[k] & lowmask, wd & lowmask);
            end
        end
        if (!exp_err && w) ref_store(a, n, wd);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 256; i++) poke_word(i, $urandom);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", {30'd0, rdy0, rdy1}, 32'd3);
        chk("rst_resp", {29'd0, vld0, err0, vld1}, 32'd0);
        chk("rst_data", data0, 32'd0);
        chk("rst_cmd_addr", {2'd0, cmd0.address}, 32'd0);
        chk("rst_cmd_wdata", cmd0.write_data, 32'd0);
        chk("rst_cmd_ctl", {26'd0, cmd0.mem_read, cmd0.mem_write, cmd0.mask_byte}, 32'd0);
        rst = 1'b1;

        // Aligned SW
        op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        chk("sw_addr", {2'd0, q_addr[0]}, 32'h40);
        chk("sw_mask", {28'd0, q_mask[0]}, 32'd15);
        chk("sw_wdata", q_wd[0], 32'hDEADBEEF);

        // SB then LB / LBU
        op(1'b1, 3'd0, 32'h102, 32'h000000A5);
        chk("sb_mask", {28'd0, q_mask[0]}, 32'd4);
        op(1'b0, 3'd0, 32'h102, 32'd0);
        chk("lb_value", o_data, 32'hFFFFFFA5);
        op(1'b0, 3'd4, 32'h102, 32'd0);
        chk("lbu_value", o_data, 32'h000000A5);

        // Misaligned LW across a word boundary
        poke_word(32'h3F, {16'h2211, 16'($urandom)});
        poke_word(32'h40, {16'($urandom), 16'h4433});
        op(1'b0, 3'd2, 32'h0FE, 32'd0);
        chk("mlw_value", o_data, 32'h44332211);
        chk("mlw_mask0", {28'd0, q_mask[0]}, 32'd4);
        chk("mlw_mask3", {28'd0, q_mask[3]}, 32'd2);
        chk("mlw_addr2", {2'd0, q_addr[2]}, 32'h40);

        // Misaligned SH: rejected by the strict unit, split by the other
        sel = 1'b1;
        op(1'b1, 3'd1, 32'h103, 32'h0000BBAA);
        op(1'b0, 3'd3, 32'h200, 32'd0);
        op(1'b0, 3'd2, 32'h202, 32'd0);
        sel = 1'b0;
        op(1'b1, 3'd1, 32'h103, 32'h0000BBAA);
        chk("msh_mask0", {28'd0, q_mask[0]}, 32'd8);
        chk("msh_mask1", {28'd0, q_mask[1]}, 32'd1);
        chk("msh_byte1", {24'd0, q_wd[1][7:0]}, 32'hBB);
        op(1'b0, 3'd5, 32'h103, 32'd0);
        chk("lhu_value", o_data, 32'h0000BBAA);

        // Illegal width codes
        op(1'b0, 3'd3, 32'h200, 32'd0);
        op(1'b1, 3'd4, 32'h200, 32'h12345678);
        op(1'b1, 3'd7, 32'h201, 32'h12345678);

        // Reset during the second byte of a misaligned SW
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h101; req_wdata = 32'h77665544;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_wr", {31'd0, cmd0.mem_write}, 32'd0);
        chk("rst_mid_ready", {31'd0, rdy0}, 32'd1);
        chk("rst_mid_valid", {31'd0, vld0}, 32'd0);
        refb[10'h101] = 8'h44;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_resp", {31'd0, vld0}, 32'd0);
        end
        op(1'b0, 3'd2, 32'h100, 32'd0);

        // Random traffic, including addresses that wrap at 2^32
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + $urandom_range(0, 3);
            else                           a = $urandom_range(0, 1023);
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
